// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg
//   Shared definitions for the SDRAM request arbiter:
//     - arb_state_e : 2-bit arbiter FSM encoding (ARB_IDLE/ISSUE/WAITLO/WAITHI)
//     - PTR_W       : width of port indices / round-robin pointer (NPORTS <= 8)
//     - rr_next()   : round-robin pointer increment with wrap at nports
package sdram_arb_pkg;

    localparam int unsigned PTR_W = 3;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ISSUE  = 2'd1,
        ARB_WAITLO = 2'd2,
        ARB_WAITHI = 2'd3
    } arb_state_e;

    // Index of the port after idx, wrapping to 0 after the last port.
    function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] idx,
                                                 input int unsigned       nports);
        logic [PTR_W-1:0] nxt;
        if (idx == PTR_W'(nports - 1)) begin
            nxt = 3'd0;
        end else begin
            nxt = idx + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// sdram_rr_pick
//   Combinational round-robin picker: selects the first set bit of req at or
//   after position ptr, wrapping at NPORTS.
// Ports:
//   req [NPORTS-1:0] in  : request vector
//   ptr [PTR_W-1:0]  in  : highest-priority position (must be < NPORTS)
//   win [NPORTS-1:0] out : one-hot winner (all zero when no request)
//   idx [PTR_W-1:0]  out : winner index (0 when no request)
//   any              out : at least one request present
module sdram_rr_pick
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NPORTS = 4
) (
    input  logic [NPORTS-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NPORTS-1:0] win,
    output logic [PTR_W-1:0]  idx,
    output logic              any
);

    logic found_s;
    logic hit_s;

    // Scan ports starting at ptr; the first requester encountered wins.
    always_comb begin
        win     = '0;
        idx     = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        for (int k = 0; k < int'(NPORTS); k++) begin
            hit_s = !found_s && req[(int'(ptr) + k) % int'(NPORTS)];
            win[(int'(ptr) + k) % int'(NPORTS)] = hit_s;
            idx     = hit_s ? PTR_W'((int'(ptr) + k) % int'(NPORTS)) : idx;
            found_s = found_s | hit_s;
        end
    end

    assign any = |req;

endmodule

// File: rtl/sdram_arb.sv
// sdram_arb
//   NPORTS-requester round-robin arbiter in front of the sdram_cnt internal
//   interface. One transaction in flight; read data returned to the owner.
// Optional feature: define SDRAM_ARB_WDOG_EN to enable a WDOG_CYC-cycle
//   watchdog that aborts a stuck transaction with an err pulse.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req/req_we [NPORTS]        : per-port request (held until gnt), write(1)/read(0)
//   req_addr [NPORTS*ADDR_W]   : port p at [p*ADDR_W +: ADDR_W]
//   req_wdata [NPORTS*DATA_W]  : port p at [p*DATA_W +: DATA_W]
//   gnt/done/rvalid/err [NPORTS]: one-cycle pulses to the owning port
//   rdata [DATA_W]             : shared registered read data
//   sdr_en/we/addr/wdata       : command to sdram_cnt
//   sdr_rdy/valid/rdata        : status and read data from sdram_cnt
module sdram_arb
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NPORTS   = 4,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned WDOG_CYC = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NPORTS-1:0]        req,
    input  logic [NPORTS-1:0]        req_we,
    input  logic [NPORTS*ADDR_W-1:0] req_addr,
    input  logic [NPORTS*DATA_W-1:0] req_wdata,
    output logic [NPORTS-1:0]        gnt,
    output logic [NPORTS-1:0]        done,
    output logic [NPORTS-1:0]        rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic [NPORTS-1:0]        err,
    output logic                     sdr_en,
    output logic                     sdr_we,
    output logic [ADDR_W-1:0]        sdr_addr,
    output logic [DATA_W-1:0]        sdr_wdata,
    input  logic                     sdr_rdy,
    input  logic                     sdr_valid,
    input  logic [DATA_W-1:0]        sdr_rdata
);

    arb_state_e          state_q, state_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                sdr_en_q, sdr_en_d;
    logic                sdr_we_q, sdr_we_d;
    logic [ADDR_W-1:0]   sdr_addr_q, sdr_addr_d;
    logic [DATA_W-1:0]   sdr_wdata_q, sdr_wdata_d;
    logic [NPORTS-1:0]   gnt_q, gnt_d;
    logic [NPORTS-1:0]   done_q, done_d;
    logic [NPORTS-1:0]   rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
`ifdef SDRAM_ARB_WDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYC + 1);
    logic [NPORTS-1:0]   err_q, err_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
`endif

    logic [NPORTS-1:0]   pick_win_s;
    logic [PTR_W-1:0]    pick_idx_s;
    logic                pick_any_s;
    logic [NPORTS-1:0]   owner_oh_s;

    sdram_rr_pick #(
        .NPORTS (NPORTS)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .win (pick_win_s),
        .idx (pick_idx_s),
        .any (pick_any_s)
    );

    assign owner_oh_s = NPORTS'(1'b1) << owner_q;

    // Next-state and next-output computation for the arbiter FSM.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        sdr_en_d    = sdr_en_q;
        sdr_we_d    = sdr_we_q;
        sdr_addr_d  = sdr_addr_q;
        sdr_wdata_d = sdr_wdata_q;
        gnt_d       = '0;
        done_d      = '0;
        rvalid_d    = '0;
        rdata_d     = rdata_q;
`ifdef SDRAM_ARB_WDOG_EN
        err_d       = '0;
        wdog_d      = wdog_q;
`endif

        // sdr_we_q still holds the op type of the transaction in flight, so
        // read data is captured only for reads and never while idle.
        if (sdr_valid && (state_q != ARB_IDLE) && !sdr_we_q) begin
            rdata_d  = sdr_rdata;
            rvalid_d = owner_oh_s;
        end else begin
            rdata_d  = rdata_q;
        end

        case (state_q)
            ARB_IDLE: begin
                if (pick_any_s) begin
                    owner_d     = pick_idx_s;
                    sdr_en_d    = 1'b1;
                    sdr_we_d    = |(req_we & pick_win_s);
                    sdr_addr_d  = req_addr[int'(pick_idx_s) * ADDR_W +: ADDR_W];
                    sdr_wdata_d = req_wdata[int'(pick_idx_s) * DATA_W +: DATA_W];
                    state_d     = ARB_ISSUE;
`ifdef SDRAM_ARB_WDOG_EN
                    wdog_d      = '0;
`endif
                end else begin
                    state_d     = ARB_IDLE;
                end
            end
            ARB_ISSUE: begin
                // rdy low (refresh) stalls the request; it is never dropped.
                if (sdr_en_q && sdr_rdy) begin
                    sdr_en_d = 1'b0;
                    gnt_d    = owner_oh_s;
                    ptr_d    = rr_next(owner_q, NPORTS);
                    state_d  = ARB_WAITLO;
                end else begin
                    state_d  = ARB_ISSUE;
                end
            end
            ARB_WAITLO: begin
                if (!sdr_rdy) begin
                    state_d = ARB_WAITHI;
                end else begin
                    state_d = ARB_WAITLO;
                end
            end
            ARB_WAITHI: begin
                if (sdr_rdy) begin
                    done_d  = owner_oh_s;
                    state_d = ARB_IDLE;
                end else begin
                    state_d = ARB_WAITHI;
                end
            end
            default: begin
                state_d  = ARB_IDLE;
                sdr_en_d = 1'b0;
            end
        endcase

`ifdef SDRAM_ARB_WDOG_EN
        // Watchdog overrides any normal transition once the limit is reached.
        if (state_q != ARB_IDLE) begin
            if (wdog_q == WDOG_W'(WDOG_CYC - 1)) begin
                state_d  = ARB_IDLE;
                sdr_en_d = 1'b0;
                gnt_d    = '0;
                done_d   = '0;
                err_d    = owner_oh_s;
                ptr_d    = rr_next(owner_q, NPORTS);
                wdog_d   = '0;
            end else begin
                wdog_d   = wdog_q + WDOG_W'(1);
            end
        end else begin
            wdog_d = '0;
        end
`endif
    end

    // Arbiter state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            sdr_en_q    <= 1'b0;
            sdr_we_q    <= 1'b0;
            sdr_addr_q  <= '0;
            sdr_wdata_q <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
`ifdef SDRAM_ARB_WDOG_EN
            err_q       <= '0;
            wdog_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            sdr_en_q    <= sdr_en_d;
            sdr_we_q    <= sdr_we_d;
            sdr_addr_q  <= sdr_addr_d;
            sdr_wdata_q <= sdr_wdata_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
`ifdef SDRAM_ARB_WDOG_EN
            err_q       <= err_d;
            wdog_q      <= wdog_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign sdr_en    = sdr_en_q;
    assign sdr_we    = sdr_we_q;
    assign sdr_addr  = sdr_addr_q;
    assign sdr_wdata = sdr_wdata_q;
`ifdef SDRAM_ARB_WDOG_EN
    assign err       = err_q;
`else
    assign err       = '0;
`endif

endmodule

// File: tb/tb_sdram_arb.sv
// tb_sdram_arb
//   Directed self-checking bench for sdram_arb with a small behavioural
//   sdram_cnt model (5-cycle busy window, read data mid-window, optional
//   refresh stall, optional stuck-after-accept mode).
module tb_sdram_arb;

    localparam int NP = 4;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int WD = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NP-1:0]    req, req_we;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_wdata;
    logic [NP-1:0]    gnt, done, rvalid, err;
    logic [DW-1:0]    rdata;
    logic             sdr_en, sdr_we;
    logic [AW-1:0]    sdr_addr;
    logic [DW-1:0]    sdr_wdata;
    logic             sdr_rdy, sdr_valid;
    logic [DW-1:0]    sdr_rdata;

    always #5 clk = ~clk;

    sdram_arb #(
        .NPORTS   (NP),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .WDOG_CYC (WD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .err       (err),
        .sdr_en    (sdr_en),
        .sdr_we    (sdr_we),
        .sdr_addr  (sdr_addr),
        .sdr_wdata (sdr_wdata),
        .sdr_rdy   (sdr_rdy),
        .sdr_valid (sdr_valid),
        .sdr_rdata (sdr_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // sdram_cnt model controls, written by the main process at negedge+1
    logic [DW-1:0] mdl_data = '0;
    int            mdl_refresh = 0;
    bit            mdl_stuck = 1'b0;
    int            mdl_cnt;
    bit            mdl_acc;

    // Model reacts on negedge: inputs settle well before the DUT samples.
    initial begin
        sdr_rdy   = 1'b1;
        sdr_valid = 1'b0;
        sdr_rdata = '0;
        mdl_cnt   = 0;
        mdl_acc   = 1'b0;
        forever begin
            @(negedge clk);
            sdr_valid = 1'b0;
            if (!rst_n) begin
                mdl_cnt = 0;
                mdl_acc = 1'b0;
                sdr_rdy = 1'b1;
            end else begin
                if (mdl_acc) begin
                    mdl_acc = 1'b0;
                    if (!mdl_stuck) mdl_cnt = 5;
                end
                if (mdl_cnt > 0) begin
                    sdr_rdy = 1'b0;
                    // valid is driven for writes too; the arbiter must ignore it
                    if (mdl_cnt == 3) begin
                        sdr_valid = 1'b1;
                        sdr_rdata = mdl_data;
                    end
                    mdl_cnt--;
                end else if (mdl_refresh > 0) begin
                    sdr_rdy = 1'b0;
                    mdl_refresh--;
                end else begin
                    sdr_rdy = 1'b1;
                end
                if (sdr_en && sdr_rdy) mdl_acc = 1'b1;
            end
        end
    end

    logic [NP-1:0] seen_gnt, seen_done, seen_rvalid, seen_err;
    bit            multi_gnt = 1'b0;

    task automatic clear_seen();
        seen_gnt = '0; seen_done = '0; seen_rvalid = '0; seen_err = '0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        seen_gnt    |= gnt;
        seen_done   |= done;
        seen_rvalid |= rvalid;
        seen_err    |= err;
        if ($countones(gnt) > 1) multi_gnt = 1'b1;
    endtask

    // sel: 0=gnt 1=done 2=rvalid 3=err. A timeout leaves v=0 and fails.
    task automatic wait_pulse(input string tag, input int sel, input logic [NP-1:0] exp, input int maxc);
        logic [NP-1:0] v;
        int n;
        v = '0;
        n = 0;
        while (v == '0 && n < maxc) begin
            step();
            v = (sel == 0) ? gnt : (sel == 1) ? done : (sel == 2) ? rvalid : err;
            n++;
        end
        check_eq(tag, 64'(v), 64'(exp));
    endtask

    initial begin
        int n;
        bit en_held;
        logic [NP-1:0] exp_port;

        rst_n = 1'b0;
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        clear_seen();
        step(); step();
        check_eq("rst_pulses", 64'({gnt, done, rvalid, err}), 64'h0);
        check_eq("rst_sdr_cmd", 64'({sdr_en, sdr_we, sdr_addr}), 64'h0);
        check_eq("rst_rdata", 64'(rdata), 64'h0);
        rst_n = 1'b1;
        step();

        // Single read, port 1
        mdl_data = 32'hDEADBEEF;
        req_addr[1*AW +: AW] = 12'h123;
        req = 4'b0010;
        step();
        check_eq("rd1_sdr_en", 64'(sdr_en), 64'h1);
        check_eq("rd1_addr_we", 64'({sdr_we, sdr_addr}), 64'h123);
        wait_pulse("rd1_gnt", 0, 4'b0010, 10);
        req = '0;
        wait_pulse("rd1_rvalid", 2, 4'b0010, 10);
        check_eq("rd1_rdata", 64'(rdata), 64'hDEADBEEF);
        wait_pulse("rd1_done", 1, 4'b0010, 10);

        // Write, port 2; model drives valid mid-busy, must be ignored
        mdl_data = 32'h12345678;
        clear_seen();
        req_addr[2*AW +: AW]  = 12'h7FF;
        req_wdata[2*DW +: DW] = 32'hA5A5A5A5;
        req_we = 4'b0100;
        req    = 4'b0100;
        step();
        check_eq("wr_we_addr", 64'({sdr_en, sdr_we, sdr_addr}), 64'h37FF);
        check_eq("wr_wdata", 64'(sdr_wdata), 64'hA5A5A5A5);
        wait_pulse("wr_gnt", 0, 4'b0100, 10);
        req = '0; req_we = '0;
        wait_pulse("wr_done", 1, 4'b0100, 10);
        check_eq("wr_no_rvalid", 64'(seen_rvalid), 64'h0);
        check_eq("wr_rdata_kept", 64'(rdata), 64'hDEADBEEF);

        // Reset while in ARB_WAITHI: outputs clear without a clock edge
        req_addr[3*AW +: AW] = 12'h456;
        req = 4'b1000;
        step();
        wait_pulse("rst_mid_gnt", 0, 4'b1000, 10);
        req = '0;
        step();
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_cmd", 64'({sdr_en, sdr_we, sdr_addr}), 64'h0);
        check_eq("async_rst_rdata", 64'(rdata), 64'h0);
        check_eq("async_rst_pulses", 64'({gnt, done, rvalid, err}), 64'h0);
        step();
        rst_n = 1'b1;

        // All ports requesting from pointer 0: order 0,1,2,3,0
        mdl_data = 32'h0BADF00D;
        multi_gnt = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_pulse($sformatf("rr_gnt%0d", k), 0, 4'(1 << (k % 4)), 20);
            wait_pulse($sformatf("rr_done%0d", k), 1, 4'(1 << (k % 4)), 20);
        end
        req = '0;
        check_eq("rr_single_gnt", 64'(multi_gnt), 64'h0);

        // Refresh stall: rdy low for 8 cycles, request held, gnt on rdy rise
        step();
        mdl_refresh = 8;
        req = 4'b0001;
        n = 0;
        en_held = 1'b1;
        while (gnt == '0 && n < 30) begin
            step();
            n++;
            if (gnt == '0 && !sdr_en) en_held = 1'b0;
        end
        check_eq("rf_en_held", 64'(en_held), 64'h1);
        check_eq("rf_gnt_cycle", 64'(n), 64'd10);
        check_eq("rf_gnt", 64'(gnt), 64'h1);
        req = '0;
        wait_pulse("rf_done", 1, 4'b0001, 20);

        // Controller accepts but never drops rdy
        step();
        clear_seen();
        mdl_stuck = 1'b1;
        req = 4'b0010;
`ifdef SDRAM_ARB_WDOG_EN
        n = 0;
        while (err == '0 && n < 40) begin
            step();
            n++;
        end
        check_eq("wd_err", 64'(err), 64'h2);
        check_eq("wd_cycle", 64'(n), 64'd17);
        check_eq("wd_gnt_no_done", 64'({seen_gnt, seen_done}), 64'h20);
        req = '0;
        mdl_stuck = 1'b0;
        exp_port = 4'b0100;
`else
        repeat (40) step();
        check_eq("hang_no_err_done", 64'({seen_err, seen_done}), 64'h0);
        check_eq("hang_gnt_en", 64'({seen_gnt, 3'b000, sdr_en}), 64'h20);
        req = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        mdl_stuck = 1'b0;
        exp_port = 4'b0010;
`endif
        // Recovery: pointer decides between ports 1 and 2
        step();
        mdl_data = 32'hCAFEF00D;
        req = 4'b0110;
        wait_pulse("rec_gnt", 0, exp_port, 10);
        req = '0;
        wait_pulse("rec_rvalid", 2, exp_port, 10);
        check_eq("rec_rdata", 64'(rdata), 64'hCAFEF00D);
        wait_pulse("rec_done", 1, exp_port, 10);
        check_eq("all_single_gnt", 64'(multi_gnt), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
